sangdon_seq: RTL and testbench

//  "Sang don" (stacking-light) LED pattern sequencer feeding the 8-bit LED byte P of the TM1638 display driver.
//  A single lit dot walks from the far end toward the stack, lands on it, and grows it until all LEDs are lit.
//  The full pattern is held, cleared, then the sequence repeats.

---
 rtl/sangdon_seq_pkg.sv | 15 +
 rtl/sangdon_seq_step_prescaler.sv | 35 +++
 rtl/sangdon_seq.sv | 150 +++++++++++++++
 tb/tb_sangdon_seq.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sangdon_seq_pkg.sv
// Shared definitions for the stacking-light LED sequencer.
package sangdon_seq_pkg;

  // Sequencer states; 2-bit encoding shared with any stage that decodes them.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FULL  = 2'd2,
    ST_CLEAR = 2'd3
  } state_e;

  // Default LED count, matching the 8-bit LED byte of the TM1638.
  localparam int unsigned N_DEFAULT = 8;

endpackage

// File: rtl/sangdon_seq_step_prescaler.sv
// Step prescaler: emits a single-cycle enable tick every DIV running cycles.
// Produces an enable, not a clock; the consumer stays on clk_50M.
module step_prescaler #(
  parameter int unsigned DIV = 4
) (
  input  logic clk_50M,
  input  logic rs,
  input  logic run,
  input  logic clr,
  output logic tick
);

  localparam int unsigned CW = $clog2(DIV);

  logic [CW-1:0] r_cnt;

  // Tick is combinational so that dropping run suppresses it in the same cycle.
  assign tick = run & (r_cnt == CW'(DIV - 1));

  // Count while running, wrap on tick, clear has priority over run.
  always_ff @(posedge clk_50M or posedge rs) begin
    if (rs) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (run) begin
      if (tick) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/sangdon_seq.sv
// Stacking-light LED sequencer: a dot walks toward the stack, lands, and grows it
// until all LEDs are lit; the full pattern is held, cleared, and the frame repeats.
import sangdon_seq_pkg::*;

module sangdon_seq #(
  parameter int unsigned N          = N_DEFAULT,
  parameter int unsigned STEP_DIV   = 12_500_000,
  parameter int unsigned HOLD_STEPS = 2
) (
  input  logic         clk_50M,
  input  logic         rs,
  input  logic         en,
  input  logic         pause,
  input  logic         dir,
  output logic [N-1:0] P,
  output logic         step_tick,
  output logic         frame_done
);

  localparam int unsigned   KW  = $clog2(N) + 1;
  localparam int unsigned   HW  = $clog2(HOLD_STEPS + 1);
  localparam logic [KW-1:0] TOP = KW'(N - 1);

  state_e        r_state, w_state_d;
  logic [KW-1:0] r_k, w_k_d;
  logic [KW-1:0] r_pos, w_pos_d;
  logic [HW-1:0] r_hold, w_hold_d;
  logic          r_dir, w_dir_d;
  logic [N-1:0]  r_p, w_p_d;
  logic [N-1:0]  w_log, w_map;
  logic          r_frame_done, w_frame_done_d;
  logic          r_step_tick;
  logic          w_tick, w_upd, w_run, w_clr;

  assign w_run = en & ~pause;
  assign w_clr = ~en;

  step_prescaler #(
    .DIV (STEP_DIV)
  ) u_prescaler (
    .clk_50M (clk_50M),
    .rs      (rs),
    .run     (w_run),
    .clr     (w_clr),
    .tick    (w_tick)
  );

  // Next-state: everything holds unless en drops or a step tick arrives.
  always_comb begin
    w_state_d      = r_state;
    w_k_d          = r_k;
    w_pos_d        = r_pos;
    w_hold_d       = r_hold;
    w_dir_d        = r_dir;
    w_frame_done_d = 1'b0;
    w_upd          = 1'b0;
    if (!en) begin
      w_state_d = ST_IDLE;
      w_k_d     = '0;
      w_pos_d   = TOP;
      w_hold_d  = '0;
      w_upd     = 1'b1;
    end else if (w_tick) begin
      w_upd = 1'b1;
      unique case (r_state)
        ST_IDLE: begin
          w_state_d = ST_RUN;
          w_k_d     = '0;
          w_pos_d   = TOP;
          w_dir_d   = dir;
        end
        ST_RUN: begin
          if (r_pos > r_k) begin
            w_pos_d = r_pos - KW'(1);
          end else if (r_k == TOP) begin
            w_state_d = ST_FULL;
            w_hold_d  = '0;
          end else begin
            w_k_d   = r_k + KW'(1);
            w_pos_d = TOP;
          end
        end
        ST_FULL: begin
          if (r_hold == HW'(HOLD_STEPS - 1)) begin
            w_state_d = ST_CLEAR;
          end else begin
            w_hold_d = r_hold + HW'(1);
          end
        end
        ST_CLEAR: begin
          w_state_d      = ST_RUN;
          w_k_d          = '0;
          w_pos_d        = TOP;
          w_dir_d        = dir;
          w_frame_done_d = 1'b1;
        end
        default: w_state_d = ST_IDLE;
      endcase
    end
  end

  // Logical (dir=0) pattern for the next state: stack of height k plus dot at pos.
  always_comb begin
    w_log = '0;
    unique case (w_state_d)
      ST_RUN: begin
        for (int i = 0; i < N; i++) begin
          w_log[i] = (KW'(i) < w_k_d) || (KW'(i) == w_pos_d);
        end
      end
      ST_FULL: w_log = '1;
      default: w_log = '0;
    endcase
  end

  // Mirror the pattern when the frame was started with dir=1.
  for (genvar gi = 0; gi < N; gi++) begin : g_map
    assign w_map[gi] = w_dir_d ? w_log[N-1-gi] : w_log[gi];
  end

  assign w_p_d = w_upd ? w_map : r_p;

  // State, counters and registered outputs.
  always_ff @(posedge clk_50M or posedge rs) begin
    if (rs) begin
      r_state      <= ST_IDLE;
      r_k          <= '0;
      r_pos        <= TOP;
      r_hold       <= '0;
      r_dir        <= 1'b0;
      r_p          <= '0;
      r_frame_done <= 1'b0;
      r_step_tick  <= 1'b0;
    end else begin
      r_state      <= w_state_d;
      r_k          <= w_k_d;
      r_pos        <= w_pos_d;
      r_hold       <= w_hold_d;
      r_dir        <= w_dir_d;
      r_p          <= w_p_d;
      r_frame_done <= w_frame_done_d;
      r_step_tick  <= w_tick;
    end
  end

  assign P          = r_p;
  assign step_tick  = r_step_tick;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_sangdon_seq.sv
// Self-checking bench for sangdon_seq (N=8, STEP_DIV=4, HOLD_STEPS=2).
module tb_sangdon_seq;

  localparam int unsigned N    = 8;
  localparam int unsigned DIV  = 4;
  localparam int unsigned HOLD = 2;

  logic       clk_50M = 1'b0;
  logic       rs      = 1'b0;
  logic       en      = 1'b0;
  logic       pause   = 1'b0;
  logic       dir     = 1'b0;
  logic [7:0] P;
  logic       step_tick;
  logic       frame_done;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  // Reference model: the frame is a precomputed list of logical patterns.
  logic [7:0] frame [$];
  bit         m_idle;
  int         m_idx;
  int         m_cnt;
  bit         m_dir;
  logic [7:0] m_p;
  logic       m_tick;
  logic       m_fd;

  logic [7:0] t1 [11];

  sangdon_seq #(
    .N          (N),
    .STEP_DIV   (DIV),
    .HOLD_STEPS (HOLD)
  ) dut (
    .clk_50M    (clk_50M),
    .rs         (rs),
    .en         (en),
    .pause      (pause),
    .dir        (dir),
    .P          (P),
    .step_tick  (step_tick),
    .frame_done (frame_done)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic logic [7:0] rev8(input logic [7:0] v);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = v[7-i];
    return r;
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic expect_found(input string tag, input bit found);
    n_vec++;
    assert (found) else begin
      n_err++;
      $error("FAIL %s observed=timeout expected=event", tag);
    end
  endtask

  task automatic model_reset();
    m_idle = 1'b1;
    m_idx  = 0;
    m_cnt  = 0;
    m_dir  = 1'b0;
    m_p    = 8'h00;
    m_tick = 1'b0;
    m_fd   = 1'b0;
  endtask

  // One clock edge of the reference behaviour, using inputs as seen at the edge.
  task automatic model_edge();
    m_tick = 1'b0;
    m_fd   = 1'b0;
    if (rs) begin
      model_reset();
    end else if (!en) begin
      m_idle = 1'b1;
      m_cnt  = 0;
      m_p    = 8'h00;
    end else if (!pause) begin
      if (m_cnt == DIV - 1) begin
        m_cnt  = 0;
        m_tick = 1'b1;
        if (m_idle) begin
          m_idle = 1'b0;
          m_idx  = 0;
          m_dir  = dir;
        end else begin
          m_idx++;
          if (m_idx == frame.size()) begin
            m_idx = 0;
            m_dir = dir;
            m_fd  = 1'b1;
          end
        end
        m_p = m_dir ? rev8(frame[m_idx]) : frame[m_idx];
      end else begin
        m_cnt++;
      end
    end
  endtask

  task automatic step();
    @(posedge clk_50M);
    model_edge();
    #1;
    cyc++;
    check("P", P, m_p);
    check("step_tick", {7'b0, step_tick}, {7'b0, m_tick});
    check("frame_done", {7'b0, frame_done}, {7'b0, m_fd});
  endtask

  initial begin
    bit found;
    int c0;
    int r;

    for (int k = 0; k < int'(N); k++) begin
      for (int pos = N - 1; pos >= k; pos--) begin
        frame.push_back(8'(((1 << k) - 1) | (1 << pos)));
      end
    end
    for (int h = 0; h < int'(HOLD); h++) frame.push_back(8'hFF);
    frame.push_back(8'h00);

    t1[0] = 8'h80; t1[1] = 8'h40; t1[2] = 8'h20; t1[3]  = 8'h10;
    t1[4] = 8'h08; t1[5] = 8'h04; t1[6] = 8'h02; t1[7]  = 8'h01;
    t1[8] = 8'h81; t1[9] = 8'h41; t1[10] = 8'h21;

    model_reset();

    // Reset state
    #2 rs = 1'b1;
    #13;
    check("rst_P", P, 8'h00);
    check("rst_step_tick", {7'b0, step_tick}, 8'h00);
    check("rst_frame_done", {7'b0, frame_done}, 8'h00);
    step();

    // Basic walk with dir=0
    rs  = 1'b0;
    en  = 1'b1;
    dir = 1'b0;
    for (int i = 0; i < 11; i++) begin
      repeat (DIV) step();
      check("t1_seq", P, t1[i]);
    end

    // Frame period and frame_done pulse
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    expect_found("wait_fd1", found);
    check("fd_P", P, 8'h80);
    c0 = cyc;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    expect_found("wait_fd2", found);
    check("frame_period", 8'(cyc - c0), 8'd156);

    // dir=1 at frame start, toggled mid-frame
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (!m_idle && m_idx == 38) found = 1'b1;
    end
    expect_found("wait_clear", found);
    dir = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      step();
      if (frame_done === 1'b1) found = 1'b1;
    end
    expect_found("wait_fd_dir1", found);
    check("dir1_start", P, 8'h01);
    repeat (3 * DIV) step();
    dir = 1'b0;
    repeat (7 * DIV) step();
    check("dir1_idx10", P, 8'h84);

    // en=0 while showing 0x83, then restart
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (m_p == 8'h83 && !m_dir) found = 1'b1;
    end
    expect_found("wait_83", found);
    en = 1'b0;
    step();
    check("en0_P", P, 8'h00);
    check("en0_fd", {7'b0, frame_done}, 8'h00);
    en = 1'b1;
    repeat (DIV) step();
    check("en1_restart", P, 8'h80);

    // pause at cnt=2 mid-RUN
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (!m_idle && m_idx < 36 && m_cnt == 2) found = 1'b1;
    end
    expect_found("wait_cnt2", found);
    pause = 1'b1;
    repeat (10) step();
    pause = 1'b0;
    step();
    check("pause_rel1", {7'b0, step_tick}, 8'h00);
    step();
    check("pause_rel2", {7'b0, step_tick}, 8'h01);

    // Asynchronous reset during FULL
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      step();
      if (!m_idle && m_idx == 36) found = 1'b1;
    end
    expect_found("wait_full", found);
    #3 rs = 1'b1;
    #1;
    check("async_rst_P", P, 8'h00);
    check("async_rst_fd", {7'b0, frame_done}, 8'h00);
    model_reset();
    repeat (2) step();
    rs = 1'b0;
    repeat (DIV) step();
    check("rst_restart", P, 8'h80);

    // Randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 999);
      if (r < 3) en = ~en;
      else if (r < 30) dir = ~dir;
      pause = ($urandom_range(0, 9) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
